mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Responder end of the cache-to-memory request protocol: services icache read requests and dcache read/write requests, one word per grant, against a single-ported RAM.
- Drives per-requester wait/load responses; the caches treat `!wait` as "word done this cycle".
- Sits between the icache/dcache pair and the RAM model.
- Arbitration is registered, dcache-priority, with an anti-starvation guard for the icache.

Parameters:
- STARVE_MAX, 4: consecutive dcache grants allowed while iREN is pending before the icache is forced a grant (range 1..15).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  icache wait; low for exactly the completing cycle
- iload  out  32  icache read data
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  dcache wait
- dload  out  32  dcache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (data/ack valid this cycle), 3 ERROR
- ram_err  out  1  sticky RAM error flag
- d_acc_cnt  out  16  completed dcache accesses (see optional feature)
- i_acc_cnt  out  16  completed icache accesses (see optional feature)

Behaviour:
- State register: IDLE, D_ACC, I_ACC. Starve counter: 4-bit, saturating.
- Reset values:
  - state IDLE, starve counter 0, ram_err 0, both access counters 0.
  - Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1.
- IDLE, next-state priority:
  1. starve counter == STARVE_MAX and iREN -> I_ACC.
  2. else dREN|dWEN -> D_ACC.
  3. else iREN -> I_ACC.
  4. else stay IDLE.
  - No RAM enables are driven in IDLE, so every grant costs one arbitration cycle.
- D_ACC:
  - ramaddr=daddr and ramstore=dstore.
  - dWEN has precedence: dWEN=1 gives ramWEN=1, ramREN=0; dREN alone gives ramREN=1.
  - dwait = (ramstate != ACCESS).
  - ramstate==ACCESS: transition to IDLE.
    - If iREN is high that cycle, starve counter +1 (saturating); otherwise clear it.
  - dREN and dWEN both drop before ACCESS (abort): de-assert enables the same cycle, go to IDLE, counter unchanged.
- I_ACC:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - iwait = (ramstate != ACCESS).
  - On ACCESS: go to IDLE and clear the starve counter.
  - iREN drops before ACCESS: abort to IDLE.
- Wait outputs: iwait=1 whenever not in I_ACC; dwait=1 whenever not in D_ACC.
- Load data: iload and dload are combinational pass-through of ramload.
- ramstate ERROR:
  - Treated as not-ready: wait stays high, state holds.
  - ram_err set, cleared only by reset.
- Simultaneous events:
  - dREN|dWEN and iREN in IDLE with counter < STARVE_MAX: dcache wins.
  - ACCESS arriving in the same cycle as a request drop: completion wins (the access is counted and the state returns to IDLE).
- Reset mid-access: enables drop asynchronously; in-flight word lost; the requester re-issues.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined:
  - d_acc_cnt increments on each D_ACC completion; i_acc_cnt on each I_ACC completion.
  - 16-bit, wrap modulo 2^16, aborts not counted.
- Undefined: both counters tied to 0, no counter flops.

Test Plan:
- Reset, then dREN=1, daddr=0x40, RAM returns ACCESS 2 cycles after ramREN with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from cycle 1; dwait low only in the ACCESS cycle; dload=0xDEADBEEF; state back to IDLE.
- dWEN=1, dREN=1, dstore=0x12345678, daddr=0x3100 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait low once at ACCESS.
- iREN and dREN held high continuously, STARVE_MAX=4, RAM ACCESS after 1 cycle -> grant sequence D,D,D,D,I,D,D,D,D,I; iwait low exactly in the 5th and 10th completions.
- dREN asserted, dropped after 1 cycle while ramstate=BUSY -> ramREN falls the same cycle; no dwait low pulse; d_acc_cnt unchanged (MEM_ARB_STATS_EN defined).
- ramstate=ERROR during I_ACC for 3 cycles, then ACCESS -> iwait stays 1 for those cycles; ram_err=1 and stays 1 after completion.
- nRST low mid D_ACC -> ramREN/ramWEN=0, dwait=iwait=1 immediately; after release, a fresh dREN completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter for the icache/dcache pair: registered dcache-priority grant with an
// icache anti-starvation guard. Define MEM_ARB_STATS_EN to enable the completed-access counters.
module mem_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        ram_err,
   output logic [15:0] d_acc_cnt,
   output logic [15:0] i_acc_cnt
);

   typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       ram_err_q;
   logic       d_req;

   assign d_req = dREN | dWEN;
   assign iload = ramload;
   assign dload = ramload;
   assign ram_err = ram_err_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= IDLE;
         starve_q  <= 4'd0;
         ram_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         ram_err_q <= ram_err_q | (ramstate == RS_ERROR);
      end
   end

   // Enables are decoded from state_q, so an async reset drops them immediately.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      case (state_q)
         IDLE: begin
            if (starve_q == STARVE_LIM && iREN) state_d = I_ACC;
            else if (d_req)                      state_d = D_ACC;
            else if (iREN)                       state_d = I_ACC;
         end
         D_ACC: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dwait    = (ramstate != RS_ACCESS);
            // Completion beats a same-cycle request drop.
            if (ramstate == RS_ACCESS) begin
               state_d  = IDLE;
               starve_d = !iREN ? 4'd0 : (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
            end else if (!d_req) begin
               state_d = IDLE;
            end
         end
         I_ACC: begin
            ramaddr = iaddr;
            ramREN  = 1'b1;
            iwait   = (ramstate != RS_ACCESS);
            if (ramstate == RS_ACCESS) begin
               state_d  = IDLE;
               starve_d = 4'd0;
            end else if (!iREN) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MEM_ARB_STATS_EN
   logic [15:0] d_cnt_q, i_cnt_q;
   logic        d_done, i_done;

   assign d_done = (state_q == D_ACC) && (ramstate == RS_ACCESS);
   assign i_done = (state_q == I_ACC) && (ramstate == RS_ACCESS);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         d_cnt_q <= 16'd0;
         i_cnt_q <= 16'd0;
      end else begin
         if (d_done) d_cnt_q <= d_cnt_q + 16'd1;
         if (i_done) i_cnt_q <= i_cnt_q + 16'd1;
      end
   end

   assign d_acc_cnt = d_cnt_q;
   assign i_acc_cnt = i_cnt_q;
`else
   assign d_acc_cnt = 16'd0;
   assign i_acc_cnt = 16'd0;
`endif

endmodule
